// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encodings,
// default operand width and the counter-width helper.
package serial_adder_pkg;

  // Default operand / result width in bits.
  localparam int DEFAULT_WIDTH = 8;

  // State encodings.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t FIN  = 2'd2;

  // Smallest r such that 2**r >= value. It sizes the bit counter, which
  // only ever needs to hold 0..WIDTH-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/FULLADDER.sv
// Existing 1-bit full adder cell: purely combinational SUM and carry.
module FULLADDER (
  input  logic A,
  input  logic B,
  input  logic CY_IN,
  output logic SUM,
  output logic CY_OUT
);

  // One-bit sum and majority carry.
  always_comb begin
    SUM    = A ^ B ^ CY_IN;
    CY_OUT = (A & B) | (A & CY_IN) | (B & CY_IN);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: captures two WIDTH-bit operands plus carry-in on an
// accepted START, adds them LSB first through a single FULLADDER cell and
// presents {CY_OUT, SUM} with a one-cycle DONE pulse.
//
// Handshake: START is sampled only in IDLE; the operands and CY_IN are
// captured on the same edge that accepts START. BUSY is high for the
// WIDTH cycles of RUN, then DONE is high for exactly one cycle (FIN), in
// which SUM/CY_OUT are already valid. SUM/CY_OUT then hold until the
// next accepted operation finishes. START during RUN or FIN is dropped,
// not queued. All outputs come from registers or from the state register.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CK,
  input  logic             RES_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CY_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             CY_OUT,
  output logic [1:0]       dbg_state
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q,  state_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] sa_q,     sa_d;
  logic [WIDTH-1:0] sb_q,     sb_d;
  logic [WIDTH-1:0] sr_q,     sr_d;
  logic             cr_q,     cr_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic             cy_out_q, cy_out_d;

  logic fa_sum;
  logic fa_co;

  // The single full-adder cell works on the current LSBs and the carry.
  FULLADDER FA0 (
    .A      (sa_q[0]),
    .B      (sb_q[0]),
    .CY_IN  (cr_q),
    .SUM    (fa_sum),
    .CY_OUT (fa_co)
  );

  // Next-state and datapath: load on accept, shift one bit per RUN cycle,
  // publish the result on the last RUN cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    cr_d     = cr_q;
    sum_d    = sum_q;
    cy_out_d = cy_out_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          sa_d    = A;
          sb_d    = B;
          cr_d    = CY_IN;
          cnt_d   = '0;
          sr_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        sr_d  = {fa_sum, sr_q[WIDTH-1:1]};
        cr_d  = fa_co;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          // The bit processed now is the MSB, so the shifted-in value is
          // the complete sum.
          state_d  = FIN;
          sum_d    = {fa_sum, sr_q[WIDTH-1:1]};
          cy_out_d = fa_co;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state, with asynchronous clear that discards any operation in flight.
  always_ff @(posedge CK or negedge RES_N) begin
    if (!RES_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      cr_q     <= 1'b0;
      sum_q    <= '0;
      cy_out_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      cr_q     <= cr_d;
      sum_q    <= sum_d;
      cy_out_q <= cy_out_d;
    end
  end

  // Status decoded from the state register; results straight from flops.
  always_comb begin
    BUSY      = (state_q == RUN);
    DONE      = (state_q == FIN);
    SUM       = sum_q;
    CY_OUT    = cy_out_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit instance for directed and random
// operations and a 2-bit instance swept exhaustively. Expected results
// come from plain integer addition held in a queue.
module tb_serial_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 8-bit instance ----------------
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cy8;
  logic [7:0] sum8;
  logic [1:0] st8;

  serial_adder #(.WIDTH(8)) dut8 (
    .CK(clk), .RES_N(rst_n), .START(start8), .A(a8), .B(b8), .CY_IN(cin8),
    .BUSY(busy8), .DONE(done8), .SUM(sum8), .CY_OUT(cy8), .dbg_state(st8)
  );

  // ---------------- 2-bit instance ----------------
  logic       start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       cin2 = 1'b0;
  logic       busy2, done2, cy2;
  logic [1:0] sum2;
  logic [1:0] st2;

  serial_adder #(.WIDTH(2)) dut2 (
    .CK(clk), .RES_N(rst_n), .START(start2), .A(a2), .B(b2), .CY_IN(cin2),
    .BUSY(busy2), .DONE(done2), .SUM(sum2), .CY_OUT(cy2), .dbg_state(st2)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
    return 9'(a) + 9'(b) + 9'(c);
  endfunction

  // ---------------- driver: one 8-bit operation ----------------
  // When inject is set, a START with different operands is pulsed during RUN;
  // it must not disturb the result.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input bit inject);
    int busy_cnt;
    bit got;
    logic [8:0] exp;
    busy_cnt = 0;
    got = 0;
    exp = '0;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
    exp_q.push_back(model8(a, b, cin));
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (k == 0) start8 = 1'b0;
      if (inject && k == 2) begin start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; end
      if (inject && k == 3) start8 = 1'b0;
      check("busy_done_excl", {31'd0, busy8 & done8}, 32'd0);
      if (done8) begin
        got = 1;
        exp = exp_q.pop_front();
        check("latency", k, 8);
        check("busy_cycles", busy_cnt, 8);
        check("sum", {24'd0, sum8}, {24'd0, exp[7:0]});
        check("cy_out", {31'd0, cy8}, {31'd0, exp[8]});
        check("state_fin", {30'd0, st8}, 32'd2);
      end else if (busy8) begin
        busy_cnt++;
      end
    end
    if (!got) begin
      check("done_timeout", 0, 1);
      void'(exp_q.pop_front());
    end else begin
      @(negedge clk);
      check("done_one_cycle", {31'd0, done8}, 32'd0);
      check("sum_hold", {23'd0, cy8, sum8}, {23'd0, exp});
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int done_seen;
    int last_done;
    int issued;
    logic [7:0] ra, rb;
    logic rc;
    bit got;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sum", {23'd0, cy8, sum8}, 32'd0);
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_done", {31'd0, done8}, 32'd0);
    check("rst_state", {30'd0, st8}, 32'd0);
    rst_n = 1'b1;

    // Directed operations
    run_op8(8'h00, 8'h00, 1'b0, 0);
    run_op8(8'hFF, 8'h01, 1'b0, 0);
    run_op8(8'h5A, 8'h3C, 1'b1, 0);
    check("dir_5a_3c", {23'd0, cy8, sum8}, 32'h097);
    run_op8(8'hFF, 8'hFF, 1'b1, 1);
    check("dir_ff_ff", {23'd0, cy8, sum8}, 32'h1FF);
    // The injected START must not have launched another operation.
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy8 || done8) done_seen++;
    end
    check("ignored_start_idle", done_seen, 0);
    check("ignored_start_sum", {23'd0, cy8, sum8}, 32'h1FF);

    // Reset in the middle of an operation
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) start8 = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_sum", {23'd0, cy8, sum8}, 32'd0);
    check("midrst_busy", {31'd0, busy8}, 32'd0);
    check("midrst_done", {31'd0, done8}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8) done_seen++;
    end
    check("midrst_no_done", done_seen, 0);
    run_op8(8'h12, 8'h34, 1'b0, 0);
    check("after_rst", {23'd0, cy8, sum8}, 32'h046);

    // Back-to-back with START held high, random operands
    @(negedge clk);
    ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255)); rc = 1'($urandom_range(0, 1));
    a8 = ra; b8 = rb; cin8 = rc; start8 = 1'b1;
    exp_q.push_back(model8(ra, rb, rc));
    issued = 1;
    done_seen = 0;
    last_done = -1;
    for (int k = 0; k < 16 * 10 + 30 && done_seen < 16; k++) begin
      @(negedge clk);
      check("b2b_busy_done_excl", {31'd0, busy8 & done8}, 32'd0);
      if (done8) begin
        logic [8:0] exp;
        exp = exp_q.pop_front();
        check("b2b_result", {23'd0, cy8, sum8}, {23'd0, exp});
        if (last_done >= 0) check("b2b_interval", k - last_done, 10);
        last_done = k;
        done_seen++;
        if (issued < 16) begin
          ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255)); rc = 1'($urandom_range(0, 1));
          a8 = ra; b8 = rb; cin8 = rc;
          exp_q.push_back(model8(ra, rb, rc));
          issued++;
        end else begin
          start8 = 1'b0;
        end
      end
    end
    start8 = 1'b0;
    check("b2b_done_count", done_seen, 16);
    exp_q.delete();

    // WIDTH=2 exhaustive
    for (int v = 0; v < 32; v++) begin
      logic [4:0] vv;
      logic [2:0] exp2;
      vv = 5'(v);
      exp2 = 3'(vv[4:3]) + 3'(vv[2:1]) + 3'(vv[0]);
      @(negedge clk);
      a2 = vv[4:3]; b2 = vv[2:1]; cin2 = vv[0]; start2 = 1'b1;
      got = 0;
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge clk);
        if (k == 0) start2 = 1'b0;
        if (done2) begin
          got = 1;
          check("w2_latency", k, 2);
          check("w2_result", {29'd0, cy2, sum2}, {29'd0, exp2});
        end
      end
      if (!got) check("w2_done_timeout", 0, 1);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
